alu_pipe: RTL
=============

# alu_pipe

Parametrised, handshaked successor to the team's combinational ALU. Accepts one operation per cycle on a valid/ready input port, registers result and a full flag set (zero/carry/negative/overflow/illegal) into a one-entry output stage with valid/ready back-pressure, adds shift/rotate ops and an optional multi-cycle shift-add multiplier. Sits between the datapath operand registers and the writeback/flags logic.

## Interface
- WIDTH, 8, operand/result width (≥4, power of two)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- a, b  in  WIDTH  operands
- c_in  in  1  carry/mode input
- opcode  in  4  operation select
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result when out_valid && out_ready
- result  out  WIDTH  result (low half for MUL)
- result_hi  out  WIDTH  high half of product; 0 for all other ops
- zero, carry, negative, overflow, illegal  out  1 each  flags

## Operation
- 0000: c_in ? a+1 : a. 0001: a+b+c_in. 0010: a+~b+c_in (c_in=1 is subtract). 0011: c_in ? a : a+{WIDTH{1}} (decrement).
- 0100 AND, 0101 OR, 0110 XOR, 0111 ~a.
- 1000 SHL, 1001 SHR logical, 1010 SAR, 1011 ROL; shift amount = b[$clog2(WIDTH)-1:0].
- 1100 MUL unsigned a*b → {result_hi,result}. 1101–1111 reserved.
- carry: carry-out of the WIDTH+1-bit sum for 0000–0011; last bit shifted out for shifts (0 for shift amount 0); 0 for logic ops and MUL.
- overflow: signed overflow for 0000–0011 (operands a and ~b for 0010); result_hi!=0 for MUL; 0 otherwise.
- zero: all result bits (including result_hi for MUL) zero. negative: result[WIDTH-1].
- illegal: 1 for reserved opcodes (and MUL when not compiled in); result=0, result_hi=0, other flags 0 except zero=1.
- FSM: IDLE, MUL_BUSY. IDLE: single-cycle op accepted → registered into output stage. MUL accepted → MUL_BUSY, counter loads WIDTH, shifts one multiplier bit per cycle; at count 0 result written to output stage, → IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready).

## Timing
- Reset: out_valid=0, result=0, result_hi=0, all flags 0, state=IDLE, counter=0; in_ready=1 once rst_n high.
- Single-cycle ops: accepted cycle T → out_valid at T+1. Full throughput with out_ready held high.
- MUL: accepted T → out_valid at T+WIDTH+1; in_ready low T+1 .. T+WIDTH+1 inclusive unless output drains.
- Stall: while out_valid && !out_ready, result/flags held stable, in_ready=0, no new op accepted.
- Simultaneous output consume and input accept in same cycle: new result replaces old at next edge, out_valid stays 1.
- Operands captured at accept; changes afterwards ignored, including during MUL_BUSY.
- rst_n low mid-MUL: aborts immediately (asynchronous), outputs to reset values; no stale result after release.

## Configuration
- ALU_MUL_EN defined: opcode 1100 is the WIDTH-cycle multiplier above.
- Not defined: multiplier and MUL_BUSY logic absent; 1100 treated as reserved (illegal=1, latency 1); result_hi tied to 0.

## Structure
- Package alu_pkg: opcode enum (4-bit), flags struct {zero,carry,negative,overflow,illegal}, FSM state enum.
- Sub-module alu_mul_seq: shift-add multiplier (start, operands, busy, done, 2·WIDTH product), instantiated only under ALU_MUL_EN.

## Test plan
- Reset held, any inputs → out_valid=0, result=0, flags 0; after release in_ready=1.
- WIDTH=8 opcode 0001 a=0xFF b=0x01 c_in=0 → next cycle result=0x00, zero=1, carry=1, overflow=0.
- Opcode 0010 a=0x80 b=0x01 c_in=1 → result=0x7F, carry=1, overflow=1; opcode 1010 a=0x90 b=0x02 → result=0xE4, carry=0, negative=1.
- Two back-to-back ADDs, out_ready low 3 cycles → first result held stable, in_ready=0, second accepted on drain cycle, delivered 1 cycle later.
- MUL a=0xFF b=0xFF with ALU_MUL_EN → out_valid 9 cycles after accept, result=0x01, result_hi=0xFE, overflow=1; without macro → illegal=1, result=0, latency 1.
- rst_n pulsed low 4 cycles into MUL → out_valid 0 immediately; after release ADD 0x02+0x03 → result=0x05, 1 cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding, flag bundle and FSM state for alu_pipe.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_INC   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_DEC   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_NOT   = 4'h7,
    OP_SHL   = 4'h8,
    OP_SHR   = 4'h9,
    OP_SAR   = 4'hA,
    OP_ROL   = 4'hB,
    OP_MUL   = 4'hC,
    OP_RSV13 = 4'hD,
    OP_RSV14 = 4'hE,
    OP_RSV15 = 4'hF
  } opcode_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
    logic illegal;
  } flags_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: radix-2 shift-add multiplier, one multiplier bit per cycle.
// 'done' is high during the cycle whose closing edge performs the last step;
// 'product' is the combinational next product, complete when 'done' is high,
// so the consumer can capture it on the same edge.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH:0]     psum;

  assign busy = (cnt != '0);
  assign done = (cnt == CW'(1));

  // One step: add multiplicand into the upper half if LSB set, then shift right.
  always_comb begin
    psum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? mcand : '0)};
    product = {psum, p_q[WIDTH-1:1]};
  end

  // Load operands on start, otherwise iterate until the counter empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      mcand <= '0;
      p_q   <= '0;
    end else if (start) begin
      cnt   <= CW'(WIDTH);
      mcand <= a;
      p_q   <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      cnt   <= cnt - 1'b1;
      p_q   <= product;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a one-entry registered output stage.
// Build option: define ALU_MUL_EN to include the WIDTH-cycle multiplier for
// opcode 1100; otherwise 1100 is reserved and result_hi is always 0.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);
  localparam int SW = $clog2(WIDTH);

  state_e             state;
  logic               accept, is_mul, mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH-1:0]   res_q, res_hi_q, r_c;
  flags_t             flg_q, f_c, mf;

  logic [SW-1:0]      sh;
  logic [WIDTH-1:0]   y, rol_w;
  logic               cy;
  logic [WIDTH:0]     sum, shl_w, shr_w, sar_w;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sh       = b[SW-1:0];

`ifdef ALU_MUL_EN
  logic mul_busy;

  assign is_mul = (opcode == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_p)
  );

  // Sequencer: park in MUL_BUSY until the multiplier's final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else begin
      case (state)
        IDLE:     if (accept && is_mul) state <= MUL_BUSY;
        MUL_BUSY: if (mul_done || !mul_busy) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_p    = '0;
  assign state    = IDLE;
`endif

  // Adder operand select: INC/DEC reuse the adder with a constant second operand.
  always_comb begin
    y  = '0;
    cy = c_in;
    case (opcode)
      OP_ADD:  y = b;
      OP_SUB:  y = ~b;
      OP_DEC:  begin y = c_in ? '0 : '1; cy = 1'b0; end
      default: ;
    endcase
    sum   = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cy};
    // Extra bit on each shift catches the last bit shifted out.
    shl_w = {1'b0, a} << sh;
    shr_w = {a, 1'b0} >> sh;
    sar_w = $unsigned($signed({a, 1'b0}) >>> sh);
    rol_w = (a << sh) | (a >> (WIDTH - int'(sh)));
  end

  // Single-cycle result and flags.
  always_comb begin
    r_c = '0;
    f_c = '0;
    case (opcode)
      OP_INC, OP_ADD, OP_SUB, OP_DEC: begin
        r_c          = sum[WIDTH-1:0];
        f_c.carry    = sum[WIDTH];
        f_c.overflow = (a[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r_c = a & b;
      OP_OR:  r_c = a | b;
      OP_XOR: r_c = a ^ b;
      OP_NOT: r_c = ~a;
      OP_SHL: begin r_c = shl_w[WIDTH-1:0]; f_c.carry = shl_w[WIDTH]; end
      OP_SHR: begin r_c = shr_w[WIDTH:1];   f_c.carry = shr_w[0];     end
      OP_SAR: begin r_c = sar_w[WIDTH:1];   f_c.carry = sar_w[0];     end
      OP_ROL: begin r_c = rol_w; f_c.carry = (sh != '0) && rol_w[0];  end
      default: f_c.illegal = 1'b1;  // reserved, and MUL when not built in
    endcase
    f_c.zero     = (r_c == '0);
    f_c.negative = r_c[WIDTH-1];
  end

  // Flags for a finished product.
  always_comb begin
    mf          = '0;
    mf.zero     = (mul_p == '0);
    mf.negative = mul_p[WIDTH-1];
    mf.overflow = |mul_p[2*WIDTH-1:WIDTH];
  end

  // Output stage: load on completion, drain on consume; load wins over drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= '0;
      res_hi_q  <= '0;
      flg_q     <= '0;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      res_q     <= mul_p[WIDTH-1:0];
      res_hi_q  <= mul_p[2*WIDTH-1:WIDTH];
      flg_q     <= mf;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      res_q     <= r_c;
      res_hi_q  <= '0;
      flg_q     <= f_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign result    = res_q;
  assign result_hi = res_hi_q;
  assign zero      = flg_q.zero;
  assign carry     = flg_q.carry;
  assign negative  = flg_q.negative;
  assign overflow  = flg_q.overflow;
  assign illegal   = flg_q.illegal;

endmodule
